// File: rtl/led_pattern_ctrl_if.sv
// Key inputs and LED-side outputs of the LED pattern sequencer.
// No handshake: keys are raw active-low levels; all outputs are registered and valid every cycle.
interface led_pattern_ctrl_if;
  logic       key_mode;
  logic       key_speed;
  logic [3:0] led_out;
  logic [1:0] mode;
  logic [1:0] speed;
  logic       step;

  modport master (
    output key_mode,
    output key_speed,
    input  led_out,
    input  mode,
    input  speed,
    input  step
  );

  modport slave (
    input  key_mode,
    input  key_speed,
    output led_out,
    output mode,
    output speed,
    output step
  );
endinterface

// File: rtl/led_pattern_ctrl.sv
// 4-LED pattern sequencer: debounced mode/speed keys, divided step timebase,
// and flow-left / flow-right / ping-pong / blink patterns.
module led_pattern_ctrl #(
  parameter logic [24:0] CNT_MAX = 25'd11_999_999,
  parameter logic [19:0] DEB_MAX = 20'd239_999
) (
  input logic               clk,
  input logic               rst_n,
  led_pattern_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_LEFT  = 2'd0,
    MODE_RIGHT = 2'd1,
    MODE_PING  = 2'd2,
    MODE_BLINK = 2'd3
  } mode_e;

  // Key path, index 0 = mode key, index 1 = speed key.
  logic [1:0]        keys_raw;
  logic [1:0]        sync1_q, sync2_q;
  logic [1:0][19:0]  deb_cnt_q, deb_cnt_d;
  logic [1:0]        deb_hit_q;
  logic [1:0]        press_q;

  assign keys_raw = {bus.key_speed, bus.key_mode};

  always_comb begin
    deb_cnt_d = deb_cnt_q;
    for (int k = 0; k < 2; k++) begin
      if (sync2_q[k]) begin
        deb_cnt_d[k] = '0;
      end else if (deb_cnt_q[k] != DEB_MAX) begin
        deb_cnt_d[k] = deb_cnt_q[k] + 20'd1;
      end
    end
  end

  // deb_hit_q lags the counter so the pulse fires only on the first cycle at DEB_MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 2'b11;
      sync2_q   <= 2'b11;
      deb_cnt_q <= '0;
      deb_hit_q <= '0;
      press_q   <= '0;
    end else begin
      sync1_q   <= keys_raw;
      sync2_q   <= sync1_q;
      deb_cnt_q <= deb_cnt_d;
      for (int k = 0; k < 2; k++) begin
        deb_hit_q[k] <= (deb_cnt_q[k] == DEB_MAX);
        press_q[k]   <= (deb_cnt_q[k] == DEB_MAX) && !deb_hit_q[k];
      end
    end
  end

  logic mode_press, speed_press, any_press;
  assign mode_press  = press_q[0];
  assign speed_press = press_q[1];
  assign any_press   = mode_press | speed_press;

  // Timebase
  logic [24:0] base_q, base_d;
  logic [1:0]  div_q, div_d;
  logic [1:0]  speed_q;
  logic [1:0]  div_last;
  logic        base_tick, step_fire;

  always_comb begin
    case (speed_q)
      2'd0:    div_last = 2'd3;
      2'd1:    div_last = 2'd1;
      default: div_last = 2'd0;
    endcase
  end

  assign base_tick = (base_q == CNT_MAX);
  assign step_fire = base_tick && (div_q == div_last);

  always_comb begin
    base_d = base_q + 25'd1;
    div_d  = div_q;
    if (any_press) begin
      base_d = '0;
      div_d  = '0;
    end else if (base_tick) begin
      base_d = '0;
      div_d  = step_fire ? 2'd0 : div_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      div_q  <= '0;
    end else begin
      base_q <= base_d;
      div_q  <= div_d;
    end
  end

  // Pattern advance; anything off-sequence collapses to the mode's start pattern.
  mode_e      mode_q, mode_nxt;
  logic [3:0] led_q, led_adv;
  logic       dir_left_q, dir_adv;
  logic       step_q;

  always_comb begin
    led_adv  = 4'b0001;
    dir_adv  = dir_left_q;
    mode_nxt = mode_e'(mode_q + 2'd1);
    case (mode_q)
      MODE_LEFT: begin
        case (led_q)
          4'b0001: led_adv = 4'b0010;
          4'b0010: led_adv = 4'b0100;
          4'b0100: led_adv = 4'b1000;
          default: led_adv = 4'b0001;
        endcase
      end
      MODE_RIGHT: begin
        case (led_q)
          4'b0001: led_adv = 4'b1000;
          4'b1000: led_adv = 4'b0100;
          4'b0100: led_adv = 4'b0010;
          default: led_adv = 4'b0001;
        endcase
      end
      MODE_PING: begin
        case (led_q)
          4'b0001: led_adv = 4'b0010;
          4'b0010: led_adv = dir_left_q ? 4'b0100 : 4'b0001;
          4'b0100: led_adv = dir_left_q ? 4'b1000 : 4'b0010;
          4'b1000: led_adv = 4'b0100;
          default: led_adv = 4'b0001;
        endcase
        if (led_adv == 4'b1000) begin
          dir_adv = 1'b0;
        end else if (led_adv == 4'b0001) begin
          dir_adv = 1'b1;
        end
      end
      MODE_BLINK: led_adv = (led_q == 4'b1111) ? 4'b0000 : 4'b1111;
    endcase
  end

  // Mode FSM; a press in the same cycle as a step suppresses that step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_LEFT;
      speed_q    <= 2'd0;
      led_q      <= 4'b0001;
      dir_left_q <= 1'b1;
      step_q     <= 1'b0;
    end else begin
      step_q <= step_fire && !any_press;
      if (mode_press) begin
        mode_q     <= mode_nxt;
        led_q      <= (mode_nxt == MODE_BLINK) ? 4'b1111 : 4'b0001;
        dir_left_q <= 1'b1;
      end else if (step_fire && !speed_press) begin
        led_q      <= led_adv;
        dir_left_q <= dir_adv;
      end
      if (speed_press) begin
        speed_q <= (speed_q == 2'd2) ? 2'd0 : speed_q + 2'd1;
      end
    end
  end

  assign bus.led_out = led_q;
  assign bus.mode    = mode_q;
  assign bus.speed   = speed_q;
  assign bus.step    = step_q;

endmodule

// File: doc/led_pattern_ctrl.md
# led_pattern_ctrl

Pattern sequencer for the 4-LED bar. Two raw push-buttons select the pattern mode and step rate. The block debounces both keys, generates the step timebase, and drives `led_out` through one of four patterns: flow-left, flow-right, ping-pong and blink. It sits between the board keys and the LED pins and replaces the fixed single-pattern water-light driver at the top level.

## Interface
- `CNT_MAX`, default 25'd11_999_999: base period is CNT_MAX+1 clk cycles (1 s at 12 MHz).
- `DEB_MAX`, default 20'd239_999: consecutive stable-low synchronized samples required to accept a key press (20 ms at 12 MHz).
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `key_mode`  in  1  raw mode button, active-low, asynchronous to clk.
- `key_speed`  in  1  raw speed button, active-low, asynchronous to clk.
- `led_out`  out  4  LED drive, 1 = LED on.
- `mode`  out  2  current mode: 0 flow-left, 1 flow-right, 2 ping-pong, 3 blink.
- `speed`  out  2  current rate: 0 slow (÷4), 1 medium (÷2), 2 fast (÷1); value 3 never occurs.
- `step`  out  1  one-cycle pulse on every cycle in which `led_out` advances by pattern step.

## Operation
- Key path, identical for each key:
  - 2-FF synchronizer.
  - 20-bit stable-low counter: increments while the synchronized level is 0, saturates at DEB_MAX, clears to 0 whenever the level is 1.
  - Registered press pulse: high for exactly one cycle when the counter reaches DEB_MAX.
  - One pulse per press. Holding the key gives no repeat. A bounce shorter than DEB_MAX gives no pulse.
- Timebase:
  - 25-bit base counter runs 0..CNT_MAX and wraps to 0.
  - base_tick asserts when the count equals CNT_MAX.
  - 2-bit divider counts base_ticks. A step fires on a base_tick when the divider equals div−1 (div = 4/2/1 for speed 0/1/2); the divider then clears.
- Patterns, one advance per step:
  - Mode 0: 0001→0010→0100→1000→0001.
  - Mode 1: 0001→1000→0100→0010→0001.
  - Mode 2: 0001→0010→0100→1000→0100→0010→0001→0010…
    - Direction flag is set to "left" on entering mode 2.
    - The flag flips when the new `led_out` is 1000 or 0001, so each end pattern is shown for one step.
  - Mode 3: 1111↔0000.
- Mode press:
  - `mode` ← (`mode`+1) mod 4.
  - `led_out` loads the start pattern of the new mode: 0001 for modes 0/1/2, 1111 for mode 3.
  - The ping-pong direction flag is set to "left".
  - Base counter and divider clear to 0.
- Speed press:
  - `speed` ← 0→1→2→0.
  - Base counter and divider clear to 0.
  - `led_out` is unchanged.
- Simultaneous events:
  - Mode press and step in the same cycle: the mode press wins; the step is dropped and `step` stays 0.
  - Speed press and step in the same cycle: the step is dropped and `step` stays 0.
  - Mode press and speed press in the same cycle: both are applied, and the counters clear.
- Any `led_out` value outside the current mode's sequence (unreachable in normal operation) is replaced by the mode's start pattern on the next step.

## Timing
- Reset, asynchronous, all outputs and state:
  - `led_out`=0001, `mode`=0, `speed`=0, `step`=0.
  - Counters, synchronizers and press pulses cleared.
  - Ping-pong direction flag = "left".
  - Synchronizers reset to 1 (key released).
- After reset release or any counter clear, the first step occurs (CNT_MAX+1)·div cycles later. Thereafter steps are periodic with the same interval.
- `step` and the `led_out` update occur on the same clock edge, registered. `step` is high during the cycle that follows that edge.
- Key latency: raw key first sampled low at edge t and held low gives the press pulse high after edge t+DEB_MAX+2. `mode`/`speed` update at edge t+DEB_MAX+3.
- Reset asserted mid-step or mid-debounce: everything returns immediately to reset values. A key still held after release must be re-counted from 0. It produces a press pulse once DEB_MAX synchronized-low samples are counted after release; this is a new press.

## Test plan
Bench parameters for all scenarios: CNT_MAX=9, DEB_MAX=4.

- Reset, no keys: `led_out` 0001→0010→0100→1000→0001, changing every 40 cycles. `step` is high for one cycle at each change.
- Three mode presses (held for 20 cycles, released for 20 cycles each):
  - `mode` reads 1, then 2, then 3.
  - In mode 2, `led_out` runs 0001,0010,0100,1000,0100,0010,0001.
  - In mode 3, `led_out` loads 1111 on entry and then toggles 1111/0000.
- Speed presses: step interval goes 40→20→10→40 cycles. `speed` reads 1, 2, 0. `led_out` is unchanged at each press.
- Bounce: pulse key_mode low for 3 cycles, 5 times → no `mode` change. Hold low for 50 cycles → exactly one increment, at edge t+7.
- Collision: align a mode press to the cycle of a scheduled step → `step` stays 0, `led_out` = start pattern, next step 40 cycles later.
- Assert rst_n for 1 cycle mid-pattern while key_speed is held → all outputs return to reset values. After release, `speed` becomes 1 once the still-held key is re-counted.
